// File: rtl/rv_pkg.sv
// Shared RISC-V load/store funct3 encodings and data-memory FSM states.
package rv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {DM_IDLE, DM_WAIT, DM_RESP} dmState_t;

endpackage

// File: rtl/dmem_lane.sv
// Byte-lane steering for the data memory: store enables/lanes, load extension, legality.
module dmem_lane
    import rv_pkg::*;
(
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic [31:0] rawWord,
    output logic [3:0]  byteEna,
    output logic [31:0] storeLanes,
    output logic [31:0] loadValue,
    output logic        bad
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic        illegal;
    logic        misalign;

    assign byteSel = rawWord[{addrLo, 3'b000} +: 8];
    assign halfSel = addrLo[1] ? rawWord[31:16] : rawWord[15:0];

    always_comb begin
        byteEna    = '0;
        storeLanes = '0;
        loadValue  = '0;
        illegal    = 1'b0;
        misalign   = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                illegal    = isStore && (funct3 == F3_BU);
                byteEna    = 4'b0001 << addrLo;
                storeLanes = {4{rawWord[7:0]}};
                loadValue  = (funct3 == F3_B) ? {{24{byteSel[7]}}, byteSel} : {24'h0, byteSel};
            end
            F3_H, F3_HU: begin
                illegal    = isStore && (funct3 == F3_HU);
                misalign   = addrLo[0];
                byteEna    = addrLo[1] ? 4'b1100 : 4'b0011;
                storeLanes = {2{rawWord[15:0]}};
                loadValue  = (funct3 == F3_H) ? {{16{halfSel[15]}}, halfSel} : {16'h0, halfSel};
            end
            F3_W: begin
                misalign   = (addrLo != 2'b00);
                byteEna    = 4'b1111;
                storeLanes = rawWord;
                loadValue  = rawWord;
            end
            default: illegal = 1'b1;
        endcase
        bad = illegal | misalign;
        // A rejected access must never touch the RAM nor leak a load value.
        if (bad) begin
            byteEna   = '0;
            loadValue = '0;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory stage: word RAM with byte/half/word access, wait-state handshake and core stall.
module dmem_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        write_ena,
    input  logic [2:0]  funct3,
    input  logic [31:0] DataAddr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        done,
    output logic        err,
    output logic        stall
);

    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    dmState_t stateQ, stateD;

    logic [31:0]           mem [2**ADDR_WIDTH];
    logic                  weQ;
    logic [2:0]            f3Q;
    logic [ADDR_WIDTH+1:0] addrQ;
    logic [31:0]           wdataQ;
    logic [3:0]            cntQ;
    logic                  errQ;
    logic [31:0]           readDataQ;

    logic                  isIdle;
    logic                  commit;
    logic                  memWrite;
    logic                  laneStore;
    logic [2:0]            laneF3;
    logic [1:0]            laneAddr;
    logic [31:0]           laneRaw;
    logic [3:0]            laneBe;
    logic [31:0]           laneStoreData;
    logic [31:0]           laneLoad;
    logic                  laneBad;
    logic [31:0]           memWord;
    logic                  unusedAddrBits;

    // Upper address bits only alias the RAM; they carry no state.
    assign unusedAddrBits = ^DataAddr[31:ADDR_WIDTH+2];

    assign isIdle  = (stateQ == DM_IDLE);
    assign commit  = (stateQ == DM_WAIT) && (cntQ == 4'd0);
    assign memWord = mem[addrQ[ADDR_WIDTH+1:2]];

    // In IDLE the lane judges the incoming request; afterwards it works on the latched one.
    assign laneStore = isIdle ? write_ena     : weQ;
    assign laneF3    = isIdle ? funct3        : f3Q;
    assign laneAddr  = isIdle ? DataAddr[1:0] : addrQ[1:0];
    assign laneRaw   = laneStore ? (isIdle ? write_data : wdataQ) : memWord;

    dmem_lane uLane (
        .isStore    (laneStore),
        .funct3     (laneF3),
        .addrLo     (laneAddr),
        .rawWord    (laneRaw),
        .byteEna    (laneBe),
        .storeLanes (laneStoreData),
        .loadValue  (laneLoad),
        .bad        (laneBad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= DM_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            DM_IDLE: if (req) stateD = laneBad ? DM_RESP : DM_WAIT;
            DM_WAIT: if (cntQ == 4'd0) stateD = DM_RESP;
            default: stateD = DM_IDLE;
        endcase
    end

    always_comb begin
        done      = (stateQ == DM_RESP);
        err       = done & errQ;
        stall     = req & ~done;
        read_data = readDataQ;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            weQ       <= 1'b0;
            f3Q       <= '0;
            addrQ     <= '0;
            wdataQ    <= '0;
            cntQ      <= '0;
            errQ      <= 1'b0;
            readDataQ <= '0;
        end else begin
            case (stateQ)
                DM_IDLE: begin
                    if (req) begin
                        weQ    <= write_ena;
                        f3Q    <= funct3;
                        addrQ  <= DataAddr[ADDR_WIDTH+1:0];
                        wdataQ <= write_data;
                        errQ   <= laneBad;
                        cntQ   <= laneBad ? 4'd0 : WaitInit;
                        if (laneBad) readDataQ <= '0;
                    end
                end
                DM_WAIT: begin
                    if (cntQ != 4'd0) begin
                        cntQ <= cntQ - 4'd1;
                    end else if (!weQ) begin
                        readDataQ <= laneLoad;
                    end
                end
                default: ;
            endcase
        end
    end

    // Gated by reset so an abort coinciding with the commit edge leaves memory untouched.
    assign memWrite = commit && weQ && !reset;

    always_ff @(posedge clk) begin
        if (memWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (laneBe[b]) mem[addrQ[ADDR_WIDTH+1:2]][8*b +: 8] <= laneStoreData[8*b +: 8];
            end
        end
    end

endmodule
